// File: rtl/spot_bank_scheduler_if.sv
// -----------------------------------------------------------------------------
// spot_bank_scheduler_if
// Purpose : ROI output stream between the spot bank scheduler and its
//           downstream consumer. One 40-bit ROI word is transferred on every
//           cycle where roi_valid and roi_ready are both high.
// Signals : roi_valid  scheduler -> consumer   word on roi_data is valid
//           roi_ready  consumer  -> scheduler  consumer accepts the word
//           roi_data   scheduler -> consumer   {x_start,y_start,x_end,y_end}
//           roi_last   scheduler -> consumer   final ROI of the frame
// Modports: master = scheduler side, slave = consumer side.
// -----------------------------------------------------------------------------
interface spot_bank_scheduler_if;
   logic        roi_valid;
   logic        roi_ready;
   logic [39:0] roi_data;
   logic        roi_last;

   modport master (
      output roi_valid,
      output roi_data,
      output roi_last,
      input  roi_ready
   );

   modport slave (
      input  roi_valid,
      input  roi_data,
      input  roi_last,
      output roi_ready
   );
endinterface

// File: rtl/spot_bank_scheduler.sv
// -----------------------------------------------------------------------------
// spot_bank_scheduler
// Purpose : Runs the spot finder over a ping-pong pair of image BRAM banks.
//           The capture side fills wr_bank while the finder analyses rd_bank.
//           A frame_done seen in IDLE swaps the banks, bumps frame_id and
//           pulses image_saved; completion is the rising edge of
//           analysis_rdy. The resulting ROIs (clamped to ROI_MAX) are then
//           streamed one 40-bit word per valid/ready handshake.
// Ports   : clk_in, reset_n (async, active low)
//           frame_done      capture finished an image in wr_bank (pulse)
//           wr_bank/rd_bank bank selects, always complementary
//           image_saved     start pulse to the spot finder
//           analysis_rdy    finder done level; num_rois = ROI count
//           roi_idx         external ROI mux select; roi_data_in = mux output
//           roi_if          ROI stream (master modport)
//           frame_id        frame counter, +1 per started analysis, wraps
//           frame_empty     pulse when an analysed frame had no ROIs
//           frames_dropped  saturating count of frame_done seen while busy
//           busy            FSM not idle
//           timeout_err     sticky analysis watchdog flag
// Option  : define SPOT_TIMEOUT_EN to enable the WAIT-state watchdog of
//           TIMEOUT_CYCLES clocks; otherwise timeout_err is tied low.
// -----------------------------------------------------------------------------
module spot_bank_scheduler #(
   parameter int unsigned ROI_MAX        = 10,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned ID_W           = 8
) (
   input  logic                  clk_in,
   input  logic                  reset_n,
   input  logic                  frame_done,
   output logic                  wr_bank,
   output logic                  rd_bank,
   output logic                  image_saved,
   input  logic                  analysis_rdy,
   input  logic [7:0]            num_rois,
   output logic [7:0]            roi_idx,
   input  logic [39:0]           roi_data_in,
   spot_bank_scheduler_if.master roi_if,
   output logic [ID_W-1:0]       frame_id,
   output logic                  frame_empty,
   output logic [15:0]           frames_dropped,
   output logic                  busy,
   output logic                  timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_LOAD,
      ST_SEND
   } state_t;

   localparam logic [7:0] ROI_MAX_C = 8'(ROI_MAX);

   state_t          state_q, state_d;
   logic            wr_bank_q, wr_bank_d;
   logic            image_saved_q, image_saved_d;
   logic            rdy_q, rdy_d;
   logic [7:0]      n_q, n_d;
   logic [7:0]      roi_idx_q, roi_idx_d;
   logic [39:0]     roi_data_q, roi_data_d;
   logic            roi_valid_q, roi_valid_d;
   logic            roi_last_q, roi_last_d;
   logic [ID_W-1:0] frame_id_q, frame_id_d;
   logic            frame_empty_q, frame_empty_d;
   logic [15:0]     frames_dropped_q, frames_dropped_d;
   logic [7:0]      n_clamped;
   logic            rdy_rise;

`ifdef SPOT_TIMEOUT_EN
   logic [31:0]     wd_cnt_q, wd_cnt_d;
   logic            timeout_err_q, timeout_err_d;
`endif

   assign n_clamped = (num_rois > ROI_MAX_C) ? ROI_MAX_C : num_rois;

   // The cycle in which image_saved is high is masked: the finder only clears
   // its done level in response to image_saved, so a level still high from
   // the previous frame is loaded into rdy_q here and can never look like a
   // fresh rising edge. A real completion must fall and rise again.
   assign rdy_rise = analysis_rdy && !rdy_q && !image_saved_q;

   always_comb begin
      state_d          = state_q;
      wr_bank_d        = wr_bank_q;
      image_saved_d    = 1'b0;
      rdy_d            = rdy_q;
      n_d              = n_q;
      roi_idx_d        = roi_idx_q;
      roi_data_d       = roi_data_q;
      roi_valid_d      = roi_valid_q;
      roi_last_d       = roi_last_q;
      frame_id_d       = frame_id_q;
      frame_empty_d    = 1'b0;
      frames_dropped_d = frames_dropped_q;
`ifdef SPOT_TIMEOUT_EN
      wd_cnt_d         = wd_cnt_q;
      timeout_err_d    = timeout_err_q;
`endif

      // Any frame_done outside IDLE is lost, including one arriving on the
      // cycle the FSM is heading back to IDLE.
      if (frame_done && (state_q != ST_IDLE) && (frames_dropped_q != 16'hFFFF)) begin
         frames_dropped_d = frames_dropped_q + 16'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (frame_done) begin
               wr_bank_d     = ~wr_bank_q;
               frame_id_d    = frame_id_q + ID_W'(1);
               image_saved_d = 1'b1;
               rdy_d         = 1'b0;
`ifdef SPOT_TIMEOUT_EN
               wd_cnt_d      = 32'd0;
`endif
               state_d       = ST_WAIT;
            end
         end

         ST_WAIT: begin
            rdy_d = analysis_rdy;
            if (rdy_rise) begin
               n_d       = n_clamped;
               roi_idx_d = 8'd0;
               if (n_clamped == 8'd0) begin
                  frame_empty_d = 1'b1;
                  state_d       = ST_IDLE;
               end else begin
                  state_d = ST_LOAD;
               end
            end
`ifdef SPOT_TIMEOUT_EN
            else if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               wd_cnt_d = wd_cnt_q + 32'd1;
            end
`endif
         end

         // roi_idx changed on the previous edge; this cycle lets the external
         // mux settle before the word is captured.
         ST_LOAD: begin
            roi_data_d  = roi_data_in;
            roi_valid_d = 1'b1;
            roi_last_d  = (roi_idx_q == (n_q - 8'd1));
            state_d     = ST_SEND;
         end

         ST_SEND: begin
            if (roi_valid_q && roi_if.roi_ready) begin
               roi_valid_d = 1'b0;
               if (roi_last_q) begin
                  state_d = ST_IDLE;
               end else begin
                  roi_idx_d = roi_idx_q + 8'd1;
                  state_d   = ST_LOAD;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         wr_bank_q        <= 1'b0;
         image_saved_q    <= 1'b0;
         rdy_q            <= 1'b0;
         n_q              <= 8'd0;
         roi_idx_q        <= 8'd0;
         roi_data_q       <= 40'd0;
         roi_valid_q      <= 1'b0;
         roi_last_q       <= 1'b0;
         frame_id_q       <= '0;
         frame_empty_q    <= 1'b0;
         frames_dropped_q <= 16'd0;
      end else begin
         state_q          <= state_d;
         wr_bank_q        <= wr_bank_d;
         image_saved_q    <= image_saved_d;
         rdy_q            <= rdy_d;
         n_q              <= n_d;
         roi_idx_q        <= roi_idx_d;
         roi_data_q       <= roi_data_d;
         roi_valid_q      <= roi_valid_d;
         roi_last_q       <= roi_last_d;
         frame_id_q       <= frame_id_d;
         frame_empty_q    <= frame_empty_d;
         frames_dropped_q <= frames_dropped_d;
      end
   end

`ifdef SPOT_TIMEOUT_EN
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt_q      <= 32'd0;
         timeout_err_q <= 1'b0;
      end else begin
         wd_cnt_q      <= wd_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   // rd_bank is derived so the two bank selects can never coincide.
   assign wr_bank          = wr_bank_q;
   assign rd_bank          = ~wr_bank_q;
   assign image_saved      = image_saved_q;
   assign roi_idx          = roi_idx_q;
   assign roi_if.roi_valid = roi_valid_q;
   assign roi_if.roi_data  = roi_data_q;
   assign roi_if.roi_last  = roi_last_q;
   assign frame_id         = frame_id_q;
   assign frame_empty      = frame_empty_q;
   assign frames_dropped   = frames_dropped_q;
   assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spot_bank_scheduler.sv
`timescale 1ns/1ps
module tb_spot_bank_scheduler;

   localparam int ROI_MAX = 10;
   localparam int TMO     = 100;

   logic        clk_in       = 1'b0;
   logic        reset_n      = 1'b0;
   logic        frame_done   = 1'b0;
   logic        analysis_rdy = 1'b0;
   logic [7:0]  num_rois     = 8'd0;
   logic        wr_bank, rd_bank, image_saved;
   logic [7:0]  roi_idx;
   logic [39:0] roi_data_in;
   logic [7:0]  frame_id;
   logic        frame_empty, busy, timeout_err;
   logic [15:0] frames_dropped;

   spot_bank_scheduler_if roi_if();

   spot_bank_scheduler #(
      .ROI_MAX        (ROI_MAX),
      .TIMEOUT_CYCLES (TMO),
      .ID_W           (8)
   ) dut (
      .clk_in         (clk_in),
      .reset_n        (reset_n),
      .frame_done     (frame_done),
      .wr_bank        (wr_bank),
      .rd_bank        (rd_bank),
      .image_saved    (image_saved),
      .analysis_rdy   (analysis_rdy),
      .num_rois       (num_rois),
      .roi_idx        (roi_idx),
      .roi_data_in    (roi_data_in),
      .roi_if         (roi_if),
      .frame_id       (frame_id),
      .frame_empty    (frame_empty),
      .frames_dropped (frames_dropped),
      .busy           (busy),
      .timeout_err    (timeout_err)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   // ---------------- external ROI store: word content encodes its index ----
   logic [23:0] salt = 24'h0;
   function automatic logic [39:0] roi_word(input logic [7:0] idx, input logic [23:0] s);
      return {idx, idx ^ 8'h3C, s};
   endfunction
   assign roi_data_in = roi_word(roi_idx, salt);

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   // ---------------- downstream ready driver ----------------
   int ready_pct = 100;
   always @(posedge clk_in) begin
      #1;
      roi_if.roi_ready = ($urandom_range(0, 99) < ready_pct);
   end

   // ---------------- monitor (samples on falling edge) ----------------
   logic [39:0] got_data[$];
   logic        got_last[$];
   int          empty_cnt = 0;
   int          inv_bad   = 0;
   int          stab_bad  = 0;
   logic        pend      = 1'b0;
   logic [39:0] pend_data;
   logic        pend_last;

   always @(negedge clk_in) begin
      if (rd_bank == wr_bank) inv_bad++;
      if (!reset_n) begin
         pend = 1'b0;
      end else begin
         if (pend && (!roi_if.roi_valid || roi_if.roi_data != pend_data ||
                      roi_if.roi_last != pend_last)) stab_bad++;
         if (roi_if.roi_valid && roi_if.roi_ready) begin
            got_data.push_back(roi_if.roi_data);
            got_last.push_back(roi_if.roi_last);
         end
         if (frame_empty) empty_cnt++;
         pend      = roi_if.roi_valid && !roi_if.roi_ready;
         pend_data = roi_if.roi_data;
         pend_last = roi_if.roi_last;
      end
   end

   // ---------------- reference model state ----------------
   logic m_wr   = 1'b0;
   int   m_id   = 0;
   int   m_drop = 0;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drop_pulse();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      if (m_drop < 65535) m_drop++;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      check("return_to_idle", busy, 0);
   endtask

   // Issue frame_done in IDLE and check the swap / start pulse.
   task automatic start_frame();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      m_wr = ~m_wr;
      m_id = (m_id + 1) % 256;
      @(negedge clk_in);
      check("image_saved_pulse", image_saved, 1);
      check("wr_bank_swap", wr_bank, m_wr);
      check("rd_bank_swap", rd_bank, !m_wr);
      check("frame_id", frame_id, m_id);
      check("busy_on_start", busy, 1);
      tick();
      check("image_saved_one_cycle", image_saved, 0);
   endtask

   typedef struct {
      int num;
      int delay;
      int rpct;
      bit stale;
      bit stall;
      int exp_n;
      bit exp_empty;
   } vec_t;

   task automatic run_frame(input vec_t v, input int drops);
      logic [39:0] held;
      int          e0;
      int          n;
      wait_idle(50);
      salt      = 24'($urandom);
      ready_pct = v.stall ? 0 : v.rpct;
      got_data.delete();
      got_last.delete();
      e0        = empty_cnt;
      num_rois  = 8'(v.num);
      start_frame();
      if (v.stale) begin
         // finder leaves its done level high; nothing may start from it
         repeat (30) tick();
         check("stale_no_stream", got_data.size(), 0);
         check("stale_still_busy", busy, 1);
         analysis_rdy = 1'b0;
         repeat (5) tick();
      end else begin
         analysis_rdy = 1'b0;
      end
      for (int i = 0; i < v.delay; i++) begin
         if (i >= 2 && i < 2 + drops) drop_pulse();
         else tick();
      end
      analysis_rdy = 1'b1;
      if (v.stall) begin
         n = 0;
         while (!roi_if.roi_valid && n < 20) begin
            tick();
            n++;
         end
         check("stall_valid_seen", roi_if.roi_valid, 1);
         held = roi_if.roi_data;
         check("stall_first_word", held, roi_word(8'd0, salt));
         for (int i = 0; i < 20; i++) begin
            if (i == 5 || i == 12) drop_pulse();
            else tick();
         end
         check("stall_no_accept", got_data.size(), 0);
         check("stall_data_held", roi_if.roi_data, held);
         check("stall_valid_held", roi_if.roi_valid, 1);
         check("stall_banks_kept", wr_bank, m_wr);
         check("stall_dropped", frames_dropped, m_drop);
         ready_pct = 100;
      end
      wait_idle(600);
      repeat (2) tick();
      check("word_count", got_data.size(), v.exp_n);
      for (int i = 0; i < got_data.size() && i < v.exp_n; i++) begin
         check("roi_word", got_data[i], roi_word(8'(i), salt));
         check("roi_last", got_last[i], (i == v.exp_n - 1) ? 1 : 0);
      end
      check("frame_empty", empty_cnt - e0, v.exp_empty ? 1 : 0);
      check("frames_dropped", frames_dropped, m_drop);
      check("bank_after_frame", wr_bank, m_wr);
      $display("frame id=%0d num_rois=%0d words=%0d empty=%0d dropped=%0d",
               m_id, v.num, got_data.size(), empty_cnt - e0, m_drop);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog");
   end

   vec_t tbl[9];

   initial begin
      vec_t v;
      int   n;
      //          num  dly rpct stale stall exp_n empty
      tbl[0] = '{  3,  50, 100,  0,    0,    3,    0 };
      tbl[1] = '{ 12,  20, 100,  0,    0,   10,    0 };
      tbl[2] = '{  0,  10, 100,  0,    0,    0,    1 };
      tbl[3] = '{ 10,   5, 100,  0,    0,   10,    0 };
      tbl[4] = '{ 11,   5,  50,  0,    0,   10,    0 };
      tbl[5] = '{  1,   8, 100,  1,    0,    1,    0 };
      tbl[6] = '{  2,  10, 100,  0,    1,    2,    0 };
      tbl[7] = '{255,   6, 100,  0,    0,   10,    0 };
      tbl[8] = '{  9,   7,  60,  1,    0,    9,    0 };

      // ---- reset state ----
      repeat (3) tick();
      check("rst_wr_bank", wr_bank, 0);
      check("rst_rd_bank", rd_bank, 1);
      check("rst_image_saved", image_saved, 0);
      check("rst_busy", busy, 0);
      check("rst_roi_valid", roi_if.roi_valid, 0);
      check("rst_roi_last", roi_if.roi_last, 0);
      check("rst_roi_idx", roi_idx, 0);
      check("rst_frame_id", frame_id, 0);
      check("rst_frame_empty", frame_empty, 0);
      check("rst_frames_dropped", frames_dropped, 0);
      check("rst_timeout_err", timeout_err, 0);
      reset_n = 1'b1;

      // ---- no action without frame_done ----
      repeat (5) tick();
      check("idle_stays_idle", busy, 0);
      check("idle_no_swap", wr_bank, 0);

      // ---- table-driven frames ----
      for (int i = 0; i < 9; i++) run_frame(tbl[i], 0);

      // ---- randomized frames against the model ----
      for (int i = 0; i < 20; i++) begin
         v.num       = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 255))
                                                   : int'($urandom_range(0, 14));
         v.delay     = $urandom_range(4, 30);
         v.rpct      = $urandom_range(25, 100);
         v.stale     = ($urandom_range(0, 3) == 0);
         v.stall     = 1'b0;
         v.exp_n     = (v.num < ROI_MAX) ? v.num : ROI_MAX;
         v.exp_empty = (v.num == 0);
         run_frame(v, $urandom_range(0, 2));
      end

      // ---- reset in the middle of a stream ----
      wait_idle(50);
      ready_pct = 0;
      salt      = 24'h123456;
      num_rois  = 8'd4;
      start_frame();
      analysis_rdy = 1'b0;
      repeat (6) tick();
      analysis_rdy = 1'b1;
      n = 0;
      while (!roi_if.roi_valid && n < 20) begin
         tick();
         n++;
      end
      check("mid_valid_up", roi_if.roi_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_valid_drop", roi_if.roi_valid, 0);
      check("async_busy_drop", busy, 0);
      check("async_wr_bank", wr_bank, 0);
      check("async_rd_bank", rd_bank, 1);
      check("async_frame_id", frame_id, 0);
      check("async_dropped", frames_dropped, 0);
      repeat (3) tick();
      reset_n   = 1'b1;
      m_wr      = 1'b0;
      m_id      = 0;
      m_drop    = 0;
      ready_pct = 100;
      got_data.delete();
      got_last.delete();
      repeat (10) tick();
      check("no_resume_words", got_data.size(), 0);
      check("no_resume_busy", busy, 0);

      // a normal frame after reset still works
      v = '{ 4, 12, 100, 0, 0, 4, 0 };
      run_frame(v, 1);

`ifdef SPOT_TIMEOUT_EN
      // ---- watchdog: finder never completes ----
      wait_idle(50);
      analysis_rdy = 1'b0;
      num_rois     = 8'd2;
      start_frame();
      n = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_in);
         if (!busy) break;
         n++;
      end
      check("timeout_wait_cycles", n, TMO);
      check("timeout_err_set", timeout_err, 1);
      check("timeout_idle", busy, 0);
      v = '{ 3, 10, 100, 0, 0, 3, 0 };
      run_frame(v, 0);
      check("timeout_err_sticky", timeout_err, 1);
`else
      check("timeout_err_tied", timeout_err, 0);
`endif

      check("bank_invariant_violations", inv_bad, 0);
      check("hold_stability_violations", stab_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
